// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_if
//   Bundles the datapath-facing signals of the hazard scoreboard.
//   master : datapath side (drives D/E/M stage register fields, the flush
//            request; receives stall, forwarding selects and md_busy)
//   slave  : scoreboard side (the mirror image)
//   Parameters NSTAGE and TW must match the scoreboard instance.
// ---------------------------------------------------------------------------
interface hazard_scoreboard_if #(
    parameter int NSTAGE = 3,
    parameter int TW     = 2
);
    localparam int FW = $clog2(NSTAGE + 1);

    // D stage decode information
    logic          d_valid;
    logic [4:0]    d_rs;
    logic [4:0]    d_rt;
    logic          d_use_rs;
    logic          d_use_rt;
    logic [TW-1:0] d_tuse_rs;
    logic [TW-1:0] d_tuse_rt;
    logic [4:0]    d_dst;
    logic [TW-1:0] d_tnew;
    logic          d_md_start;
    logic          d_md_div;
    logic          d_md_use;
    // Later-stage source registers
    logic [4:0]    e_rs;
    logic [4:0]    e_rt;
    logic [4:0]    m_rt;
    // Exception / eret flush of E and M
    logic          flush;
    // Control outputs
    logic          stall;
    logic [FW-1:0] fwd_d_rs;
    logic [FW-1:0] fwd_d_rt;
    logic [FW-1:0] fwd_e_rs;
    logic [FW-1:0] fwd_e_rt;
    logic [FW-1:0] fwd_m_rt;
    logic          md_busy;

    modport master (
        output d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
               d_dst, d_tnew, d_md_start, d_md_div, d_md_use,
               e_rs, e_rt, m_rt, flush,
        input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
               d_dst, d_tnew, d_md_start, d_md_div, d_md_use,
               e_rs, e_rt, m_rt, flush,
        output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   Shift-register scoreboard for the pipelined MIPS core. Each slot records
//   an in-flight destination register and its remaining Tnew; D-stage Tuse
//   values are compared against it to produce the stall, and the slot index
//   of the youngest matching writer becomes the forwarding-mux select.
//   A mult/div busy counter interlocks HI/LO users.
//
// Ports
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high; clears all slots and the md counter
//   hif    : hazard_scoreboard_if.slave
//            inputs  d_* decode fields, e_rs/e_rt, m_rt, flush
//            outputs stall, fwd_d_rs/rt, fwd_e_rs/rt, fwd_m_rt, md_busy
//            fwd value 0 = register file, k = result held in slot k-1
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NSTAGE   = 3,
    parameter int TW       = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave hif
);
    localparam int FW     = $clog2(NSTAGE + 1);
    localparam int MD_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CW     = $clog2(MD_MAX + 1);

    typedef struct packed {
        logic          valid;
        logic [4:0]    dst;
        logic [TW-1:0] tnew;
    } slot_t;

    slot_t [NSTAGE-1:0] slot_r;
    slot_t [NSTAGE-1:0] slot_nxt_s;
    logic  [CW-1:0]     md_cnt_r;
    logic  [CW-1:0]     md_cnt_nxt_s;

    logic [FW-1:0] sel_d_rs_s;
    logic [FW-1:0] sel_d_rt_s;
    logic [TW-1:0] tnew_d_rs_s;
    logic [TW-1:0] tnew_d_rt_s;
    logic          haz_rs_s;
    logic          haz_rt_s;
    logic          data_stall_s;
    logic          md_stall_s;
    logic          stall_s;
    logic          issue_s;

    // Youngest valid writer of r at slot index >= first, as index+1 (0 = none).
    // Scanning oldest to youngest lets the lowest index overwrite the result.
    function automatic logic [FW-1:0] find_writer(
        input slot_t [NSTAGE-1:0] s,
        input logic  [4:0]        r,
        input int                 first
    );
        logic [FW-1:0] sel;
        sel = {FW{1'b0}};
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if ((i >= first) && s[i].valid && (s[i].dst == r) && (r != 5'd0)) begin
                sel = FW'(i + 1);
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    // Tnew of the slot named by a select value (0 when the select is 0).
    function automatic logic [TW-1:0] tnew_at(
        input slot_t [NSTAGE-1:0] s,
        input logic  [FW-1:0]     sel
    );
        logic [TW-1:0] t;
        t = {TW{1'b0}};
        for (int i = 0; i < NSTAGE; i++) begin
            if (sel == FW'(i + 1)) begin
                t = s[i].tnew;
            end else begin
                t = t;
            end
        end
        return t;
    endfunction

    // D-stage hazard detection, stall and issue decision.
    always_comb begin
        sel_d_rs_s   = find_writer(slot_r, hif.d_rs, 0);
        sel_d_rt_s   = find_writer(slot_r, hif.d_rt, 0);
        tnew_d_rs_s  = tnew_at(slot_r, sel_d_rs_s);
        tnew_d_rt_s  = tnew_at(slot_r, sel_d_rt_s);
        haz_rs_s     = hif.d_use_rs && (sel_d_rs_s != {FW{1'b0}}) && (tnew_d_rs_s > hif.d_tuse_rs);
        haz_rt_s     = hif.d_use_rt && (sel_d_rt_s != {FW{1'b0}}) && (tnew_d_rt_s > hif.d_tuse_rt);
        data_stall_s = hif.d_valid && (haz_rs_s || haz_rt_s);
        md_stall_s   = hif.d_valid && hif.d_md_use && (md_cnt_r != {CW{1'b0}});
        stall_s      = data_stall_s || md_stall_s;
        // flush dominates a stall: nothing issues while E/M are being killed
        issue_s      = hif.d_valid && !stall_s && !hif.flush;
    end

    // Next slot contents: age every slot by one with saturating Tnew, load slot 0.
    always_comb begin
        slot_nxt_s = '0;
        for (int i = 1; i < NSTAGE; i++) begin
            slot_nxt_s[i].valid = slot_r[i-1].valid;
            slot_nxt_s[i].dst   = slot_r[i-1].dst;
            if (slot_r[i-1].tnew != {TW{1'b0}}) begin
                slot_nxt_s[i].tnew = slot_r[i-1].tnew - TW'(1);
            end else begin
                slot_nxt_s[i].tnew = {TW{1'b0}};
            end
        end
        if (issue_s) begin
            slot_nxt_s[0].valid = (hif.d_dst != 5'd0);
            slot_nxt_s[0].dst   = hif.d_dst;
            slot_nxt_s[0].tnew  = hif.d_tnew;
        end else begin
            slot_nxt_s[0] = '0;
        end
        // The instruction leaving E is killed; W and older keep advancing.
        if (hif.flush) begin
            slot_nxt_s[1] = '0;
        end else begin
            slot_nxt_s[1] = slot_nxt_s[1];
        end
    end

    // Next mult/div busy count: load on issue of a mult/div, else count down.
    always_comb begin
        md_cnt_nxt_s = md_cnt_r;
        if (issue_s && hif.d_md_start) begin
            md_cnt_nxt_s = hif.d_md_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (md_cnt_r != {CW{1'b0}}) begin
            md_cnt_nxt_s = md_cnt_r - CW'(1);
        end else begin
            md_cnt_nxt_s = md_cnt_r;
        end
    end

    // Scoreboard and busy-counter state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_r   <= '0;
            md_cnt_r <= {CW{1'b0}};
        end else begin
            slot_r   <= slot_nxt_s;
            md_cnt_r <= md_cnt_nxt_s;
        end
    end

    // D forwarding only when the value already exists; E/M look past the
    // instructions at or behind themselves.
    assign hif.stall    = stall_s;
    assign hif.fwd_d_rs = (tnew_d_rs_s == {TW{1'b0}}) ? sel_d_rs_s : {FW{1'b0}};
    assign hif.fwd_d_rt = (tnew_d_rt_s == {TW{1'b0}}) ? sel_d_rt_s : {FW{1'b0}};
    assign hif.fwd_e_rs = find_writer(slot_r, hif.e_rs, 1);
    assign hif.fwd_e_rt = find_writer(slot_r, hif.e_rt, 1);
    assign hif.fwd_m_rt = find_writer(slot_r, hif.m_rt, 2);
    assign hif.md_busy  = (md_cnt_r != {CW{1'b0}});

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//   Directed scenarios with literal expectations, then randomized traffic
//   compared every cycle against a history-based reference model: the model
//   keeps the last NSTAGE issue records and derives the remaining Tnew from
//   each record's age; the md interlock is a "busy until cycle" timestamp.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;
    localparam int NSTAGE   = 3;
    localparam int TW       = 2;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    hazard_scoreboard_if #(.NSTAGE(NSTAGE), .TW(TW)) hif ();

    hazard_scoreboard #(
        .NSTAGE(NSTAGE), .TW(TW), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        int dst;
        int tnew;
    } rec_t;

    rec_t hist[$];       // newest record at the back = current slot 0
    int   cyc        = 0;
    int   busy_until = 0;
    bit   exp_issue  = 1'b0;

    int m_srs, m_trs, m_srt, m_trt, m_tx;
    bit m_haz, m_busy, m_stall;

    function automatic int find(input int r, input int first, output int tn);
        rec_t e;
        tn = 0;
        if (r == 0) return 0;
        for (int k = first; k < NSTAGE; k++) begin
            if (k < hist.size()) begin
                e = hist[hist.size() - 1 - k];
                if (e.v && e.dst == r) begin
                    tn = (e.tnew > k) ? e.tnew - k : 0;
                    return k + 1;
                end
            end
        end
        return 0;
    endfunction

    // compare at negedge, advance model at posedge
    initial begin
        rec_t rec;
        forever begin
            @(negedge clk);
            if (reset) begin
                hist.delete();
                busy_until = 0;
                cyc        = 0;
                exp_issue  = 1'b0;
            end else begin
                m_srs   = find(int'(hif.d_rs), 0, m_trs);
                m_srt   = find(int'(hif.d_rt), 0, m_trt);
                m_haz   = (hif.d_use_rs && m_srs != 0 && m_trs > int'(hif.d_tuse_rs)) ||
                          (hif.d_use_rt && m_srt != 0 && m_trt > int'(hif.d_tuse_rt));
                m_busy  = (cyc < busy_until);
                m_stall = hif.d_valid && (m_haz || (hif.d_md_use && m_busy));
                exp_issue = hif.d_valid && !m_stall && !hif.flush;
                check("m_stall",    int'(hif.stall),    int'(m_stall));
                check("m_fwd_d_rs", int'(hif.fwd_d_rs), (m_srs != 0 && m_trs == 0) ? m_srs : 0);
                check("m_fwd_d_rt", int'(hif.fwd_d_rt), (m_srt != 0 && m_trt == 0) ? m_srt : 0);
                check("m_fwd_e_rs", int'(hif.fwd_e_rs), find(int'(hif.e_rs), 1, m_tx));
                check("m_fwd_e_rt", int'(hif.fwd_e_rt), find(int'(hif.e_rt), 1, m_tx));
                check("m_fwd_m_rt", int'(hif.fwd_m_rt), find(int'(hif.m_rt), 2, m_tx));
                check("m_md_busy",  int'(hif.md_busy),  int'(m_busy));
            end
            @(posedge clk);
            if (reset) begin
                hist.delete();
                busy_until = 0;
                cyc        = 0;
            end else begin
                cyc++;
                if (hif.flush && hist.size() > 0) begin
                    rec = hist[hist.size() - 1];
                    rec.v = 1'b0;
                    hist[hist.size() - 1] = rec;
                end
                rec.v    = exp_issue && (hif.d_dst != 5'd0);
                rec.dst  = int'(hif.d_dst);
                rec.tnew = int'(hif.d_tnew);
                hist.push_back(rec);
                while (hist.size() > NSTAGE) void'(hist.pop_front());
                if (exp_issue && hif.d_md_start)
                    busy_until = cyc + (hif.d_md_div ? DIV_LAT : MULT_LAT);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_in();
        hif.d_valid    = 1'b0;
        hif.d_rs       = 5'd0;
        hif.d_rt       = 5'd0;
        hif.d_use_rs   = 1'b0;
        hif.d_use_rt   = 1'b0;
        hif.d_tuse_rs  = 2'd0;
        hif.d_tuse_rt  = 2'd0;
        hif.d_dst      = 5'd0;
        hif.d_tnew     = 2'd0;
        hif.d_md_start = 1'b0;
        hif.d_md_div   = 1'b0;
        hif.d_md_use   = 1'b0;
        hif.e_rs       = 5'd0;
        hif.e_rt       = 5'd0;
        hif.m_rt       = 5'd0;
        hif.flush      = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle_in();
        repeat (NSTAGE) step();
    endtask

    initial begin
        int tn;
        idle_in();
        #2;
        check("rst_stall",    int'(hif.stall),    0);
        check("rst_fwd_d_rs", int'(hif.fwd_d_rs), 0);
        check("rst_fwd_e_rs", int'(hif.fwd_e_rs), 0);
        check("rst_md_busy",  int'(hif.md_busy),  0);
        #20 reset = 1'b0;
        step();

        // lw $5 (tnew 2) then add rs=$5 (tuse 1)
        hif.d_valid = 1'b1; hif.d_dst = 5'd5; hif.d_tnew = 2'd2;
        #1 check("lw_no_stall", int'(hif.stall), 0);
        step();
        check("model_lw_slot", find(5, 0, tn), 1);
        check("model_lw_tnew", tn, 2);
        idle_in();
        hif.d_valid = 1'b1; hif.d_rs = 5'd5; hif.d_use_rs = 1'b1; hif.d_tuse_rs = 2'd1;
        hif.d_dst = 5'd6; hif.d_tnew = 2'd1;
        #1 check("add_stall", int'(hif.stall), 1);
        step();
        #1 check("add_issue", int'(hif.stall), 0);
        step();
        idle_in();
        hif.e_rs = 5'd5;
        #1 check("add_fwd_e_w", int'(hif.fwd_e_rs), 3);

        // add $8 (tnew 1) then beq rs=$8 (tuse 0)
        drain();
        hif.d_valid = 1'b1; hif.d_dst = 5'd8; hif.d_tnew = 2'd1;
        step();
        idle_in();
        hif.d_valid = 1'b1; hif.d_rs = 5'd8; hif.d_use_rs = 1'b1; hif.d_tuse_rs = 2'd0;
        #1 check("beq_stall", int'(hif.stall), 1);
        check("beq_fwd_wait", int'(hif.fwd_d_rs), 0);
        step();
        #1 check("beq_go", int'(hif.stall), 0);
        check("beq_fwd_m", int'(hif.fwd_d_rs), 2);
        step();

        // jal then jr $31
        drain();
        hif.d_valid = 1'b1; hif.d_dst = 5'd31; hif.d_tnew = 2'd0;
        step();
        idle_in();
        hif.d_valid = 1'b1; hif.d_rs = 5'd31; hif.d_use_rs = 1'b1;
        #1 check("jr_stall", int'(hif.stall), 0);
        check("jr_fwd_e", int'(hif.fwd_d_rs), 1);
        step();

        // mult then mflo, div then mflo
        for (int d = 0; d < 2; d++) begin
            drain();
            hif.d_valid = 1'b1; hif.d_md_start = 1'b1; hif.d_md_use = 1'b1;
            hif.d_md_div = (d == 1);
            step();
            idle_in();
            hif.d_valid = 1'b1; hif.d_md_use = 1'b1;
            for (int c = 0; c < ((d == 1) ? DIV_LAT : MULT_LAT); c++) begin
                #1 check("md_stall", int'(hif.stall), 1);
                check("md_busy_on", int'(hif.md_busy), 1);
                step();
            end
            #1 check("md_release", int'(hif.stall), 0);
            check("md_busy_off", int'(hif.md_busy), 0);
            step();
        end

        // $0 never matches
        drain();
        hif.d_valid = 1'b1; hif.d_dst = 5'd0; hif.d_tnew = 2'd2;
        step();
        idle_in();
        hif.d_valid = 1'b1; hif.d_use_rs = 1'b1; hif.e_rs = 5'd0;
        #1 check("r0_stall", int'(hif.stall), 0);
        check("r0_fwd_d", int'(hif.fwd_d_rs), 0);
        check("r0_fwd_e", int'(hif.fwd_e_rs), 0);
        step();

        // lw $3, flush, then reader of $3
        drain();
        hif.d_valid = 1'b1; hif.d_dst = 5'd3; hif.d_tnew = 2'd2;
        step();
        idle_in();
        hif.flush = 1'b1;
        step();
        idle_in();
        hif.d_valid = 1'b1; hif.d_rs = 5'd3; hif.d_use_rs = 1'b1; hif.e_rs = 5'd3;
        #1 check("flush_stall", int'(hif.stall), 0);
        check("flush_fwd_d", int'(hif.fwd_d_rs), 0);
        check("flush_fwd_e", int'(hif.fwd_e_rs), 0);
        step();

        // async reset during a running div
        drain();
        hif.d_valid = 1'b1; hif.d_md_start = 1'b1; hif.d_md_div = 1'b1; hif.d_md_use = 1'b1;
        step();
        idle_in();
        step();
        step();
        #1 check("div_busy", int'(hif.md_busy), 1);
        #1 reset = 1'b1;
        #1 check("async_rst_busy", int'(hif.md_busy), 0);
        step();
        @(posedge clk);
        #2 reset = 1'b0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            if (i == 1500 || $urandom_range(0, 499) == 0) begin
                idle_in();
                reset = 1'b1;
                step();
                step();
                reset = 1'b0;
            end
            hif.d_valid    = ($urandom_range(0, 3) != 0);
            hif.d_rs       = 5'($urandom_range(0, 3));
            hif.d_rt       = 5'($urandom_range(0, 3));
            hif.d_use_rs   = 1'($urandom_range(0, 1));
            hif.d_use_rt   = 1'($urandom_range(0, 1));
            hif.d_tuse_rs  = 2'($urandom_range(0, 3));
            hif.d_tuse_rt  = 2'($urandom_range(0, 3));
            hif.d_dst      = 5'($urandom_range(0, 3));
            hif.d_tnew     = 2'($urandom_range(0, 3));
            hif.d_md_start = ($urandom_range(0, 19) == 0);
            hif.d_md_div   = 1'($urandom_range(0, 1));
            hif.d_md_use   = hif.d_md_start || ($urandom_range(0, 9) == 0);
            hif.e_rs       = 5'($urandom_range(0, 3));
            hif.e_rt       = 5'($urandom_range(0, 3));
            hif.m_rt       = 5'($urandom_range(0, 3));
            hif.flush      = ($urandom_range(0, 15) == 0);
        end
        step();
        idle_in();
        step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
